irq_controller: RTL

- 8-input interrupt controller, a reduced 8259 subset, on the same 16-bit data_m I/O bus as the PIT.
- Sits directly downstream of the PIT: the PIT intr drives irq_in[0]; the other lines come from UART, PS/2 and other peripherals.
- Latches rising edges into IRR, masks them with IMR and resolves fixed priority against ISR.
- Raises intr to the core, supplies the vector on the core's inta pulse, and retires service on EOI.

---
 rtl/irq_controller_pkg.sv | 24 ++
 rtl/irq_controller_if.sv | 23 ++
 rtl/irq_controller_priority.sv | 17 +
 rtl/irq_controller.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
// Shared constants for the 8-input interrupt controller: register offsets,
// command codes and reset values.
package irq_controller_pkg;

    typedef logic [7:0] irq_vec_t;

    // Word offsets within the controller's I/O window
    localparam logic ADDR_CMD   = 1'b0;   // command (byte 0) / IMR (byte 1)
    localparam logic ADDR_VBASE = 1'b1;   // vector base (byte 0)

    // Command codes written to byte 0 of the command word
    localparam irq_vec_t EOI_NONSPEC   = 8'h20;
    localparam irq_vec_t EOI_SPEC_BASE = 8'h60;
    localparam irq_vec_t READ_IRR      = 8'h0A;
    localparam irq_vec_t READ_ISR      = 8'h0B;

    localparam irq_vec_t IMR_RESET = 8'hFF;

    // True for 8'h60..8'h67, the specific-EOI family
    function automatic logic is_spec_eoi(input irq_vec_t cmd);
        return (cmd[7:3] == EOI_SPEC_BASE[7:3]);
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// data_m I/O bus slice seen by the interrupt controller.
interface irq_controller_if;
    logic        cs;
    logic [1:1]  data_m_addr;
    logic [15:0] data_m_data_in;
    logic [15:0] data_m_data_out;
    logic [1:0]  data_m_bytesel;
    logic        data_m_wr_en;
    logic        data_m_access;
    logic        data_m_ack;

    modport master (
        output cs, data_m_addr, data_m_data_in, data_m_bytesel,
               data_m_wr_en, data_m_access,
        input  data_m_data_out, data_m_ack
    );

    modport slave (
        input  cs, data_m_addr, data_m_data_in, data_m_bytesel,
               data_m_wr_en, data_m_access,
        output data_m_data_out, data_m_ack
    );
endinterface

// File: rtl/irq_controller_priority.sv
// Lowest-index-set-bit encoder; bit 0 has the highest priority.
module irq_priority (
    input  logic [7:0] req_i,
    output logic       valid_o,
    output logic [2:0] idx_o
);

    // Scan from the top so the lowest set bit is the last one to win
    always_comb begin
        valid_o = |req_i;
        idx_o   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_i[i]) idx_o = 3'(i);
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Reduced 8259-style interrupt controller: edge capture into IRR, masking
// through IMR, fixed priority against ISR, vector on inta, retire on EOI.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int       NUM_IRQS          = 8,
    parameter irq_vec_t VECTOR_BASE_RESET = 8'h08
) (
    input  logic                clk,
    input  logic                reset,
    irq_controller_if.slave     bus,
    input  logic [NUM_IRQS-1:0] irq_in,
    input  logic                inta,
    output logic                intr,
    output irq_vec_t            irq_vector
);

    irq_vec_t    irr_q, irr_d;
    irq_vec_t    isr_q, isr_d;
    irq_vec_t    imr_q, imr_d;
    irq_vec_t    vbase_q, vbase_d;
    irq_vec_t    last_irq_q;
    logic        read_isr_q, read_isr_d;
    logic        intr_q;
    irq_vec_t    vector_q, vector_d;
    logic        ack_q;
    logic [15:0] rdata_q, rdata_d;

    irq_vec_t    irq_edge;
    irq_vec_t    pend;
    irq_vec_t    eoi_clr;
    irq_vec_t    inta_set;
    irq_vec_t    cmd;
    logic        cand_valid, isr_valid;
    logic [2:0]  cand_idx, isr_idx;
    logic        eligible;
    logic        wr_cyc, rd_cyc;
    logic        cmd_wr, imr_wr, vbase_wr;

    assign irq_edge = irq_in & ~last_irq_q;
    assign pend     = irr_q & ~imr_q;
    assign cmd      = bus.data_m_data_in[7:0];

    irq_priority u_pend_prio (
        .req_i   (pend),
        .valid_o (cand_valid),
        .idx_o   (cand_idx)
    );

    irq_priority u_isr_prio (
        .req_i   (isr_q),
        .valid_o (isr_valid),
        .idx_o   (isr_idx)
    );

    // A candidate may only preempt service at strictly lower priority
    assign eligible = cand_valid & (~isr_valid | (cand_idx < isr_idx));

    assign wr_cyc   = bus.cs & bus.data_m_access & bus.data_m_wr_en;
    assign rd_cyc   = bus.cs & bus.data_m_access & ~bus.data_m_wr_en;
    assign cmd_wr   = wr_cyc & (bus.data_m_addr == ADDR_CMD) & bus.data_m_bytesel[0];
    assign imr_wr   = wr_cyc & (bus.data_m_addr == ADDR_CMD) & bus.data_m_bytesel[1];
    assign vbase_wr = wr_cyc & (bus.data_m_addr == ADDR_VBASE) & bus.data_m_bytesel[0];

    // EOI decode works on ISR as it stood before this cycle
    always_comb begin
        eoi_clr = '0;
        if (cmd_wr) begin
            if (cmd == EOI_NONSPEC) begin
                if (isr_valid) eoi_clr[isr_idx] = 1'b1;
            end else if (is_spec_eoi(cmd)) begin
                eoi_clr[cmd[2:0]] = 1'b1;
            end
        end
    end

    // Acknowledge moves the candidate from IRR to ISR; a fresh edge still wins IRR
    always_comb begin
        inta_set = (inta & eligible) ? (8'b1 << cand_idx) : '0;
        irr_d    = (irr_q & ~inta_set) | irq_edge;
        isr_d    = (isr_q & ~eoi_clr) | inta_set;
        vector_d = vector_q;
        if (inta) vector_d = vbase_q + (eligible ? {5'b0, cand_idx} : 8'd7);
    end

    // Configuration register updates
    always_comb begin
        imr_d      = imr_wr ? bus.data_m_data_in[15:8] : imr_q;
        vbase_d    = vbase_wr ? {bus.data_m_data_in[7:3], 3'b000} : vbase_q;
        read_isr_d = read_isr_q;
        if (cmd_wr && cmd == READ_IRR) read_isr_d = 1'b0;
        if (cmd_wr && cmd == READ_ISR) read_isr_d = 1'b1;
    end

    // Read mux; only enabled bytes of a read cycle return data
    always_comb begin
        rdata_d = '0;
        if (rd_cyc) begin
            if (bus.data_m_addr == ADDR_CMD) begin
                if (bus.data_m_bytesel[0]) rdata_d[7:0]  = read_isr_q ? isr_q : irr_q;
                if (bus.data_m_bytesel[1]) rdata_d[15:8] = imr_q;
            end else if (bus.data_m_bytesel[0]) begin
                rdata_d[7:0] = vbase_q;
            end
        end
    end

    // State registers; reset discards all pending and in-service state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irr_q      <= '0;
            isr_q      <= '0;
            imr_q      <= IMR_RESET;
            vbase_q    <= VECTOR_BASE_RESET;
            last_irq_q <= '0;
            read_isr_q <= 1'b0;
            intr_q     <= 1'b0;
            vector_q   <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            irr_q      <= irr_d;
            isr_q      <= isr_d;
            imr_q      <= imr_d;
            vbase_q    <= vbase_d;
            last_irq_q <= irq_in;
            read_isr_q <= read_isr_d;
            intr_q     <= eligible;
            vector_q   <= vector_d;
            ack_q      <= bus.cs & bus.data_m_access;
            rdata_q    <= rdata_d;
        end
    end

    assign intr                = intr_q;
    assign irq_vector          = vector_q;
    assign bus.data_m_ack      = ack_q;
    assign bus.data_m_data_out = rdata_q;

endmodule
